alu_md: RTL and testbench

//  Parametrised successor to the single-cycle ALU. Executes the full ALU op set with

---
 rtl/alu_md.sv | 237 +++++++++++++++++++++++
 tb/tb_alu_md.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md.sv
// alu_md: EX-stage ALU with registered outputs plus an iterative
// multiply/divide unit that owns the HI/LO registers. Single-cycle ops
// issue back-to-back; mult/div stall issue through in_ready for
// WIDTH+1 cycles and report through out_valid at latency WIDTH+2.
module alu_md #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       ALUCtrl,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             Zero,
    output logic             O,
    output logic             Sign,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz,
    output logic             busy
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_ADDU = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_SUBU = 5'b00011;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_NOR  = 5'b00110;
    localparam logic [4:0] OP_XOR  = 5'b00111;
    localparam logic [4:0] OP_SLT  = 5'b01000;
    localparam logic [4:0] OP_SLTU = 5'b01001;
    localparam logic [4:0] OP_SLL  = 5'b01010;
    localparam logic [4:0] OP_SRL  = 5'b01011;
    localparam logic [4:0] OP_SRA  = 5'b01100;
    localparam logic [4:0] OP_LUI  = 5'b01101;
    localparam logic [4:0] OP_MFHI = 5'b10100;
    localparam logic [4:0] OP_MFLO = 5'b10101;
    localparam logic [4:0] OP_MTHI = 5'b10110;
    localparam logic [4:0] OP_MTLO = 5'b10111;

    localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_SIGN
    } state_t;

    state_t           state;
    logic [SHW-1:0]   cnt;
    logic [WIDTH-1:0] acc;      // mul: upper product half; div: partial remainder
    logic [WIDTH-1:0] low;      // mul: multiplier/lower half; div: dividend/quotient
    logic [WIDTH-1:0] opb;      // |B|: multiplicand or divisor
    logic [WIDTH-1:0] a_raw;    // original A, returned in HI on divide by zero
    logic             is_div;
    logic             neg_res;  // operand signs differ (signed ops only)
    logic             neg_rem;  // A was negative (signed div only)
    logic             dz_pend;  // divisor was zero

    // Single-cycle ALU result
    logic [WIDTH-1:0] alu_res;
    logic             alu_ov;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] dif;
    logic [SHW-1:0]   shamt;

    // Mult/div operand conditioning and iteration datapath
    logic             is_md;
    logic             md_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH-1:0] div_dif;
    logic             div_ge;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] sgn_hi;
    logic [WIDTH-1:0] sgn_lo;

    assign in_ready = (state == ST_IDLE);
    assign busy     = ~in_ready;

    // Combinational result and overflow of the single-cycle op set
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        alu_res = '0;
        alu_ov  = 1'b0;
        sum     = A + B;
        dif     = A - B;
        shamt   = A[SHW-1:0];
        case (ALUCtrl)
            OP_ADD: begin
                alu_res = sum;
                alu_ov  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = dif;
                alu_ov  = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUBU: alu_res = dif;
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_NOR:  alu_res = ~(A | B);
            OP_XOR:  alu_res = A ^ B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLL:  alu_res = B << shamt;
            OP_SRL:  alu_res = B >> shamt;
            OP_SRA:  alu_res = $signed(B) >>> shamt;
            OP_LUI:  alu_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_MFHI: alu_res = hi;
            OP_MFLO: alu_res = lo;
            OP_MTHI: alu_res = A;
            OP_MTLO: alu_res = A;
            default: alu_res = '0;  // reserved codes, and mult/div (reported later)
        endcase
    end

    // Operand magnitudes, one shift-add / restoring-subtract step, and sign fix-up
    always_comb begin
        is_md     = (ALUCtrl[4:2] == 3'b100);
        md_signed = ~ALUCtrl[0];
        a_neg     = md_signed & A[WIDTH-1];
        b_neg     = md_signed & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;

        mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, opb} : '0);

        div_sh    = {acc, low[WIDTH-1]};
        div_ge    = (div_sh >= {1'b0, opb});
        div_dif   = div_sh[WIDTH-1:0] - opb;   // exact whenever div_ge is set

        prod      = {acc, low};
        prod_s    = neg_res ? -prod : prod;

        sgn_hi    = prod_s[2*WIDTH-1:WIDTH];
        sgn_lo    = prod_s[WIDTH-1:0];
        if (is_div) begin
            if (dz_pend) begin
                sgn_lo = '1;
                sgn_hi = a_raw;
            end else begin
                sgn_lo = neg_res ? -low : low;
                sgn_hi = neg_rem ? -acc : acc;
            end
        end
    end

    // Issue/iterate/sign FSM with all outputs and HI/LO registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            acc       <= '0;
            low       <= '0;
            opb       <= '0;
            a_raw     <= '0;
            is_div    <= 1'b0;
            neg_res   <= 1'b0;
            neg_rem   <= 1'b0;
            dz_pend   <= 1'b0;
            out_valid <= 1'b0;
            result    <= '0;
            Zero      <= 1'b0;
            O         <= 1'b0;
            Sign      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            dz        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values.
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (is_md) begin
                            state   <= ALUCtrl[1] ? ST_DIV : ST_MUL;
                            cnt     <= '0;
                            acc     <= '0;
                            low     <= a_mag;
                            opb     <= b_mag;
                            a_raw   <= A;
                            is_div  <= ALUCtrl[1];
                            neg_res <= a_neg ^ b_neg;
                            neg_rem <= a_neg;
                            dz_pend <= (B == '0);
                        end else begin
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            Zero      <= (alu_res == '0);
                            O         <= alu_ov;
                            Sign      <= alu_res[WIDTH-1];
                            if (ALUCtrl == OP_MTHI) hi <= A;
                            if (ALUCtrl == OP_MTLO) lo <= A;
                        end
                    end
                end
                ST_MUL: begin
                    acc <= mul_sum[WIDTH:1];
                    low <= {mul_sum[0], low[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= ST_SIGN;
                end
                ST_DIV: begin
                    acc <= div_ge ? div_dif : div_sh[WIDTH-1:0];
                    low <= {low[WIDTH-2:0], div_ge};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) state <= ST_SIGN;
                end
                ST_SIGN: begin
                    hi        <= sgn_hi;
                    lo        <= sgn_lo;
                    if (is_div) dz <= dz_pend;
                    out_valid <= 1'b1;
                    result    <= sgn_lo;
                    Zero      <= (sgn_lo == '0);
                    O         <= 1'b0;
                    Sign      <= sgn_lo[WIDTH-1];
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: table-driven check of the single-cycle op set plus directed
// multi-cycle sequences for mult/div, issue stall and reset abort.
module tb_alu_md;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ALUCtrl;
    logic        out_valid;
    logic [31:0] result;
    logic        Zero;
    logic        O;
    logic        Sign;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        s;
    } vec_t;

    vec_t vecs[$];

    alu_md #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .ALUCtrl   (ALUCtrl),
        .out_valid (out_valid),
        .result    (result),
        .Zero      (Zero),
        .O         (O),
        .Sign      (Sign),
        .hi        (hi),
        .lo        (lo),
        .dz        (dz),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One single-cycle op: accepted on the next edge, result visible right after it
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        in_valid = 1'b1;
        A        = v.a;
        B        = v.b;
        ALUCtrl  = v.op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check($sformatf("v%0d out_valid", idx), {63'd0, out_valid}, 64'd1);
        check($sformatf("v%0d result", idx), {32'd0, result}, {32'd0, v.res});
        check($sformatf("v%0d Zero", idx), {63'd0, Zero}, {63'd0, v.z});
        check($sformatf("v%0d O", idx), {63'd0, O}, {63'd0, v.o});
        check($sformatf("v%0d Sign", idx), {63'd0, Sign}, {63'd0, v.s});
    endtask

    // One mult/div op: checks latency, stall length, HI/LO, dz and flags
    task automatic run_md(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic exp_dz);
        int k;
        int busy_n;
        @(negedge clk);
        in_valid = 1'b1;
        A        = a;
        B        = b;
        ALUCtrl  = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        k        = 1;
        busy_n   = 0;
        while (!out_valid && k < 100) begin
            if (!in_ready) busy_n++;
            @(posedge clk);
            #1;
            k++;
        end
        check({nm, " latency"}, 64'(k), 64'd34);
        check({nm, " busy cycles"}, 64'(busy_n), 64'd33);
        check({nm, " in_ready"}, {63'd0, in_ready}, 64'd1);
        check({nm, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
        check({nm, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
        check({nm, " result"}, {32'd0, result}, {32'd0, exp_lo});
        check({nm, " dz"}, {63'd0, dz}, {63'd0, exp_dz});
        check({nm, " Zero"}, {63'd0, Zero}, {63'd0, (exp_lo == 32'd0)});
        check({nm, " Sign"}, {63'd0, Sign}, {63'd0, exp_lo[31]});
        check({nm, " O"}, {63'd0, O}, 64'd0);
    endtask

    initial begin
        int k;
        int pulses;
        vec_t v;

        //            op        a             b             res           z     o     s
        vecs.push_back(vec_t'{5'b00000, 32'h40000000, 32'h40000000, 32'h80000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{5'b00000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1, 1'b1});
        vecs.push_back(vec_t'{5'b00000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b00001, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{5'b00010, 32'h00000001, 32'h00000002, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{5'b00010, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0});
        vecs.push_back(vec_t'{5'b00011, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{5'b00100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{5'b00101, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b00110, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{5'b00111, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01000, 32'h00000001, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01000, 32'h00000002, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01001, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01010, 32'h00000024, 32'h00000001, 32'h00000010, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01010, 32'h0000001F, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{5'b01011, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01100, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0, 1'b1});
        vecs.push_back(vec_t'{5'b01101, 32'h00000000, 32'h00000002, 32'h00020000, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b01101, 32'h00000000, 32'hFFFF1234, 32'h12340000, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b11000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b10110, 32'h00001234, 32'h00000000, 32'h00001234, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b10111, 32'h0000ABCD, 32'h00000000, 32'h0000ABCD, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b11111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b10100, 32'h00000000, 32'h00000000, 32'h00001234, 1'b0, 1'b0, 1'b0});
        vecs.push_back(vec_t'{5'b10101, 32'h00000000, 32'h00000000, 32'h0000ABCD, 1'b0, 1'b0, 1'b0});

        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        B        = '0;
        ALUCtrl  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst out_valid", {63'd0, out_valid}, 64'd0);
        check("rst result", {32'd0, result}, 64'd0);
        check("rst flags", {61'd0, Zero, O, Sign}, 64'd0);
        check("rst hi", {32'd0, hi}, 64'd0);
        check("rst lo", {32'd0, lo}, 64'd0);
        check("rst dz", {63'd0, dz}, 64'd0);
        check("rst in_ready", {63'd0, in_ready}, 64'd1);
        check("rst busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-cycle table
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);
        check("mt hi", {32'd0, hi}, 64'h1234);
        check("mt lo", {32'd0, lo}, 64'hABCD);

        // out_valid is a pulse; result and flags hold afterwards
        @(posedge clk);
        #1;
        check("pulse drop", {63'd0, out_valid}, 64'd0);
        check("result hold", {32'd0, result}, 64'hABCD);

        // Back-to-back issue
        @(negedge clk);
        in_valid = 1'b1;
        ALUCtrl  = 5'b00000;
        A        = 32'd1;
        B        = 32'd2;
        @(posedge clk);
        #1;
        check("b2b first", {32'd0, result}, 64'd3);
        @(negedge clk);
        ALUCtrl  = 5'b00111;
        A        = 32'd3;
        B        = 32'd5;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("b2b second valid", {63'd0, out_valid}, 64'd1);
        check("b2b second", {32'd0, result}, 64'd6);

        // Multiply / divide
        run_md("mult -3*5", 5'b10000, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
        run_md("multu max^2", 5'b10001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        run_md("mult minneg*-1", 5'b10000, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_md("div -7/2", 5'b10010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_md("div 7/-2", 5'b10010, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
        run_md("div minneg/-1", 5'b10010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_md("divu 7/0", 5'b10011, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF, 1'b1);
        v = vec_t'{5'b00001, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0};
        apply(v, 100);
        check("dz sticky", {63'd0, dz}, 64'd1);
        run_md("divu 100/7", 5'b10011, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_md("div -5/0", 5'b10010, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);

        // mflo held on in_valid during a mult: accepted in the out_valid cycle
        @(negedge clk);
        in_valid = 1'b1;
        ALUCtrl  = 5'b10000;
        A        = 32'd6;
        B        = 32'd7;
        @(posedge clk);
        #1;
        ALUCtrl  = 5'b10101;
        A        = 32'h0BAD0BAD;
        B        = 32'h0;
        k        = 1;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("held latency", 64'(k), 64'd34);
        check("held mult result", {32'd0, result}, 64'd42);
        check("held in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("held mflo valid", {63'd0, out_valid}, 64'd1);
        check("held mflo result", {32'd0, result}, 64'd42);
        check("held hi", {32'd0, hi}, 64'd0);

        // Reset 10 cycles into a divide aborts it
        @(negedge clk);
        in_valid = 1'b1;
        ALUCtrl  = 5'b10011;
        A        = 32'd100;
        B        = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort out_valid", {63'd0, out_valid}, 64'd0);
        check("abort result", {32'd0, result}, 64'd0);
        check("abort flags", {61'd0, Zero, O, Sign}, 64'd0);
        check("abort hi", {32'd0, hi}, 64'd0);
        check("abort lo", {32'd0, lo}, 64'd0);
        check("abort dz", {63'd0, dz}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort in_ready", {63'd0, in_ready}, 64'd1);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        check("abort no out_valid", 64'(pulses), 64'd0);
        check("abort hi after", {32'd0, hi}, 64'd0);
        check("abort lo after", {32'd0, lo}, 64'd0);
        v = vec_t'{5'b10101, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0};
        apply(v, 101);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
